// File: rtl/adder_pkg.sv
// ------------------------------------------------------------------
// adder_pkg : shared FSM state type and nibble width for the serial adder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fourBitAdder_FourByOne.sv
// ------------------------------------------------------------------
// fourBitAdder_FourByOne : 4-bit + 4-bit + carry-in adder, one nibble slice
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fourBitAdder_FourByOne
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);

  logic [NIBBLE_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};
  assign o_sum  = w_full[NIBBLE_W-1:0];
  assign o_cout = w_full[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ------------------------------------------------------------------
// nibble_serial_adder : W-bit adder computed one nibble per cycle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*N_NIBBLES-1:0]   a,
  input  logic [4*N_NIBBLES-1:0]   b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*N_NIBBLES-1:0]   sum,
  output logic                     cout,
  output logic                     busy
);

  localparam int W     = N_NIBBLES * NIBBLE_W;
  localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

  state_t                r_state;
  state_t                w_next;
  logic [W-1:0]          r_a;
  logic [W-1:0]          r_b;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_carry;
  logic [W-1:0]          r_sum;
  logic                  r_cout;
  logic                  r_out_valid;
  logic [NIBBLE_W-1:0]   w_a_nib;
  logic [NIBBLE_W-1:0]   w_b_nib;
  logic [NIBBLE_W-1:0]   w_nib_sum;
  logic                  w_nib_cout;
  logic                  w_last;
  logic                  w_accept;

  assign w_last   = (r_idx == IDX_W'(N_NIBBLES - 1));
  assign w_accept = in_valid && (r_state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = ADD;
      ADD:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Nibble select for the current index feeding the single adder slice
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < N_NIBBLES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  fourBitAdder_FourByOne u_nib_add (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_nib_sum),
    .o_cout (w_nib_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        ADD: begin
          for (int i = 0; i < N_NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
          end
          r_carry <= w_nib_cout;
          // Index parks at the last nibble; only a new accept clears it
          if (w_last) begin
            r_cout      <= w_nib_cout;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

`default_nettype wire
